// File: rtl/doppler_sweep_pkg.sv
// rtl/doppler_sweep_pkg.sv - shared mode encodings, FSM states and default widths for the doppler sweep sequencer
package doppler_sweep_pkg;

  localparam int DWELL_W_DEFAULT = 16;
  localparam int STEPS_W_DEFAULT = 12;

  localparam logic [1:0] MODE_SINGLE   = 2'b00;
  localparam logic [1:0] MODE_REPEAT   = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter with a one-cycle terminal flag
module dwell_timer
  import doppler_sweep_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               M100CLK,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               term
);

  logic [DWELL_W-1:0] cnt;
  logic               armed;

  // Count down from the loaded value; the flag fires once per load when zero is reached
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - 1'b1;
    end else begin
      armed <= 1'b0;
    end
  end

  assign term = armed && (cnt == '0);

endmodule

// File: rtl/doppler_sweep_ctrl.sv
// rtl/doppler_sweep_ctrl.sv - single/sawtooth/triangle frequency sweep sequencer driving the NCO doppler word
module doppler_sweep_ctrl
  import doppler_sweep_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT,
  parameter int STEPS_W = STEPS_W_DEFAULT
) (
  input  logic               M100CLK,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_start,
  input  logic [31:0]        cfg_step,
  input  logic [STEPS_W-1:0] cfg_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               abort,
  output logic [31:0]        doppler_shift,
  output logic               nco_reset,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] step_idx
);

  state_t             state_q, state_d;
  logic [31:0]        shift_q, shift_d;
  logic [STEPS_W-1:0] idx_q, idx_d;
  logic               nco_q, nco_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               up_q, up_d;

  logic [31:0]        start_q, start_d;
  logic [31:0]        step_q, step_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [DWELL_W-1:0] dwell_m1_q, dwell_m1_d;
  logic [1:0]         mode_q, mode_d;

  logic               accept;
  logic               term;
  logic               timer_load;
  logic [DWELL_W-1:0] timer_val;

  // Timer holds "cycles remaining after this one", so a dwell of 0 or 1 both load 0
  function automatic logic [DWELL_W-1:0] dwell_minus_one(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign cfg_ready  = (state_q == ST_IDLE);
  assign accept     = cfg_ready && cfg_valid && !abort;
  assign timer_load = accept || ((state_q != ST_IDLE) && term);
  assign timer_val  = accept ? dwell_minus_one(cfg_dwell) : dwell_m1_q;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .M100CLK  (M100CLK),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .term     (term)
  );

  // State, output and latched-config registers
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      nco_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      up_q       <= 1'b1;
      start_q    <= '0;
      step_q     <= '0;
      steps_q    <= '0;
      dwell_m1_q <= '0;
      mode_q     <= MODE_SINGLE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      nco_q      <= nco_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      up_q       <= up_d;
      start_q    <= start_d;
      step_q     <= step_d;
      steps_q    <= steps_d;
      dwell_m1_q <= dwell_m1_d;
      mode_q     <= mode_d;
    end
  end

  // Next-state and next-output decode; step actions happen only at the end of a dwell
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    nco_d      = 1'b0;
    done_d     = 1'b0;
    up_d       = up_q;
    start_d    = start_q;
    step_d     = step_q;
    steps_d    = steps_q;
    dwell_m1_d = dwell_m1_q;
    mode_d     = mode_q;

    if (abort) begin
      state_d = ST_IDLE;
      shift_d = '0;
      idx_d   = '0;
      up_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            start_d    = cfg_start;
            step_d     = cfg_step;
            steps_d    = cfg_steps;
            dwell_m1_d = dwell_minus_one(cfg_dwell);
            mode_d     = (cfg_mode == 2'b11) ? MODE_SINGLE : cfg_mode;
            state_d    = ST_PRIME;
            shift_d    = cfg_start;
            idx_d      = '0;
            nco_d      = 1'b1;
            up_d       = 1'b1;
          end
        end
        ST_PRIME, ST_SWEEP: begin
          if (state_q == ST_PRIME) begin
            state_d = ST_SWEEP;
          end
          if (term) begin
            if (up_q) begin
              if (idx_q != steps_q) begin
                idx_d   = idx_q + 1'b1;
                shift_d = shift_q + step_q;
              end else begin
                case (mode_q)
                  MODE_REPEAT: begin
                    shift_d = start_q;
                    idx_d   = '0;
                  end
                  MODE_TRIANGLE: begin
                    // With a single value there is nothing to turn around on; just hold it
                    if (steps_q != '0) begin
                      up_d    = 1'b0;
                      idx_d   = idx_q - 1'b1;
                      shift_d = shift_q - step_q;
                    end
                  end
                  default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                  end
                endcase
              end
            end else begin
              // Bottom of the triangle turns straight back up so index 0 is held one dwell only
              if (idx_q != '0) begin
                idx_d   = idx_q - 1'b1;
                shift_d = shift_q - step_q;
              end else begin
                up_d    = 1'b1;
                idx_d   = idx_q + 1'b1;
                shift_d = shift_q + step_q;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign doppler_shift = shift_q;
  assign step_idx      = idx_q;
  assign nco_reset     = nco_q;
  assign done          = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_doppler_sweep_ctrl.sv
// tb/tb_doppler_sweep_ctrl.sv - self-checking bench for doppler_sweep_ctrl
module tb_doppler_sweep_ctrl;

  logic        M100CLK = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start;
  logic [31:0] cfg_step;
  logic [11:0] cfg_steps;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic        abort;
  logic [31:0] doppler_shift;
  logic        nco_reset;
  logic        busy;
  logic        done;
  logic [11:0] step_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 M100CLK = ~M100CLK;

  doppler_sweep_ctrl dut (
    .M100CLK       (M100CLK),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_start     (cfg_start),
    .cfg_step      (cfg_step),
    .cfg_steps     (cfg_steps),
    .cfg_dwell     (cfg_dwell),
    .cfg_mode      (cfg_mode),
    .abort         (abort),
    .doppler_shift (doppler_shift),
    .nco_reset     (nco_reset),
    .busy          (busy),
    .done          (done),
    .step_idx      (step_idx)
  );

  typedef struct {
    string       name;
    logic [31:0] st;
    logic [31:0] sp;
    int          n;
    int          d;
    logic [1:0]  m;
    int          t;
    logic [31:0] e_shift;
    int          e_idx;
    logic        e_nco;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pack(input logic [31:0] sh, input logic [11:0] ix,
                                       input logic nco, input logic bsy, input logic dn,
                                       input logic rdy);
    return {8'h00, sh, 4'h0, ix, 4'h0, nco, bsy, dn, rdy};
  endfunction

  // Expected outputs t cycles after the PRIME cycle, from the sweep rules directly
  function automatic logic [63:0] model(input logic [31:0] st, input logic [31:0] sp,
                                        input int n, input int d, input logic [1:0] m,
                                        input int t);
    int dd;
    int k;
    int idx;
    int p;
    dd = (d == 0) ? 1 : d;
    k  = t / dd;
    if (m == 2'b00 || m == 2'b11) begin
      if (k > n)
        return pack(st + sp * 32'(n), 12'(n), 1'b0, 1'b0, (t == (n + 1) * dd), 1'b1);
      idx = k;
    end else if (m == 2'b01) begin
      idx = k % (n + 1);
    end else begin
      if (n == 0) idx = 0;
      else begin
        p   = k % (2 * n);
        idx = (p <= n) ? p : 2 * n - p;
      end
    end
    return pack(st + sp * 32'(idx), 12'(idx), (t == 0), 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [63:0] exp);
    logic [63:0] got;
    got = pack(doppler_shift, step_idx, nco_reset, busy, done, cfg_ready);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got shift=%h idx=%0d nco=%b busy=%b done=%b ready=%b, required shift=%h idx=%0d nco=%b busy=%b done=%b ready=%b",
               name, got[55:24], got[19:8], got[3], got[2], got[1], got[0],
               exp[55:24], exp[19:8], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge M100CLK);
    #1;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic apply_cfg(input logic [31:0] st, input logic [31:0] sp, input int n,
                           input int d, input logic [1:0] m);
    cfg_valid = 1'b1;
    cfg_start = st;
    cfg_step  = sp;
    cfg_steps = 12'(n);
    cfg_dwell = 16'(d);
    cfg_mode  = m;
    tick();
    cfg_valid = 1'b0;
    cfg_start = $urandom;
    cfg_step  = $urandom;
    cfg_steps = 12'($urandom);
    cfg_dwell = 16'($urandom);
    cfg_mode  = 2'($urandom);
  endtask

  task automatic add(input string nm, input logic [31:0] st, input logic [31:0] sp,
                     input int n, input int d, input logic [1:0] m, input int t,
                     input logic [31:0] es, input int ei, input logic en, input logic eb,
                     input logic ed, input logic er);
    vec_t v;
    v.name = nm; v.st = st; v.sp = sp; v.n = n; v.d = d; v.m = m; v.t = t;
    v.e_shift = es; v.e_idx = ei; v.e_nco = en; v.e_busy = eb; v.e_done = ed; v.e_ready = er;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    cfg_start = '0; cfg_step = '0; cfg_steps = '0; cfg_dwell = '0; cfg_mode = '0;
    tick();
    tick();
    check("reset_state", pack(32'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    reset = 1'b0;
    tick();
    check("idle_after_reset", pack(32'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    add("single_t0",   32'h1000, 32'h100, 3, 4, 2'b00, 0,  32'h1000, 0, 1, 1, 0, 0);
    add("single_t3",   32'h1000, 32'h100, 3, 4, 2'b00, 3,  32'h1000, 0, 0, 1, 0, 0);
    add("single_t4",   32'h1000, 32'h100, 3, 4, 2'b00, 4,  32'h1100, 1, 0, 1, 0, 0);
    add("single_t11",  32'h1000, 32'h100, 3, 4, 2'b00, 11, 32'h1200, 2, 0, 1, 0, 0);
    add("single_t12",  32'h1000, 32'h100, 3, 4, 2'b00, 12, 32'h1300, 3, 0, 1, 0, 0);
    add("single_t15",  32'h1000, 32'h100, 3, 4, 2'b00, 15, 32'h1300, 3, 0, 1, 0, 0);
    add("single_done", 32'h1000, 32'h100, 3, 4, 2'b00, 16, 32'h1300, 3, 0, 0, 1, 1);
    add("single_post", 32'h1000, 32'h100, 3, 4, 2'b00, 17, 32'h1300, 3, 0, 0, 0, 1);
    add("tri_t1",      32'h0, 32'h1, 2, 1, 2'b10, 1, 32'h1, 1, 0, 1, 0, 0);
    add("tri_t2",      32'h0, 32'h1, 2, 1, 2'b10, 2, 32'h2, 2, 0, 1, 0, 0);
    add("tri_t3",      32'h0, 32'h1, 2, 1, 2'b10, 3, 32'h1, 1, 0, 1, 0, 0);
    add("tri_t4",      32'h0, 32'h1, 2, 1, 2'b10, 4, 32'h0, 0, 0, 1, 0, 0);
    add("tri_t6",      32'h0, 32'h1, 2, 1, 2'b10, 6, 32'h2, 2, 0, 1, 0, 0);
    add("tri_t8",      32'h0, 32'h1, 2, 1, 2'b10, 8, 32'h0, 0, 0, 1, 0, 0);
    add("wrap_t1",     32'hFFFF_FFFE, 32'h3, 1, 2, 2'b00, 1, 32'hFFFF_FFFE, 0, 0, 1, 0, 0);
    add("wrap_t2",     32'hFFFF_FFFE, 32'h3, 1, 2, 2'b00, 2, 32'h0000_0001, 1, 0, 1, 0, 0);
    add("wrap_done",   32'hFFFF_FFFE, 32'h3, 1, 2, 2'b00, 4, 32'h0000_0001, 1, 0, 0, 1, 1);
    add("d0_t0",       32'hABCD, 32'h5, 0, 0, 2'b00, 0, 32'hABCD, 0, 1, 1, 0, 0);
    add("d0_done",     32'hABCD, 32'h5, 0, 0, 2'b00, 1, 32'hABCD, 0, 0, 0, 1, 1);
    add("mode11_done", 32'h5, 32'h2, 1, 1, 2'b11, 2, 32'h7, 1, 0, 0, 1, 1);
    add("rep_t5",      32'h10, 32'h10, 2, 2, 2'b01, 5, 32'h30, 2, 0, 1, 0, 0);
    add("rep_reload",  32'h10, 32'h10, 2, 2, 2'b01, 6, 32'h10, 0, 0, 1, 0, 0);
    add("rep_n0_hold", 32'h77, 32'h10, 0, 3, 2'b01, 7, 32'h77, 0, 0, 1, 0, 0);
    add("tri_n0_hold", 32'h88, 32'h10, 0, 1, 2'b10, 5, 32'h88, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      go_idle();
      apply_cfg(vecs[i].st, vecs[i].sp, vecs[i].n, vecs[i].d, vecs[i].m);
      repeat (vecs[i].t) tick();
      check(vecs[i].name, pack(vecs[i].e_shift, 12'(vecs[i].e_idx), vecs[i].e_nco,
                               vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ready));
    end

    // Abort in the 3rd cycle of step 1 of a repeat sweep, with a competing config
    go_idle();
    apply_cfg(32'h100, 32'h10, 3, 4, 2'b01);
    repeat (6) tick();
    check("abort_pre", pack(32'h110, 12'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    abort = 1'b1;
    cfg_valid = 1'b1; cfg_start = 32'h5555; cfg_steps = 12'd2; cfg_dwell = 16'd1; cfg_mode = 2'b00;
    tick();
    abort = 1'b0; cfg_valid = 1'b0;
    check("abort_next", pack(32'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    check("abort_no_accept", pack(32'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    // Back-to-back: new config accepted on the done cycle of a 1-cycle single sweep
    apply_cfg(32'h1234, 32'h1, 0, 0, 2'b00);
    check("b2b_prime", pack(32'h1234, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("b2b_done", pack(32'h1234, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply_cfg(32'h9000, 32'h1, 1, 1, 2'b00);
    check("b2b_second_prime", pack(32'h9000, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("b2b_second_step", pack(32'h9001, 12'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    check("b2b_second_done", pack(32'h9001, 12'd1, 1'b0, 1'b0, 1'b1, 1'b1));

    // Reset mid-sweep with a config presented during reset
    apply_cfg(32'h5000, 32'h1, 7, 3, 2'b01);
    repeat (4) tick();
    reset = 1'b1;
    cfg_valid = 1'b1; cfg_start = 32'h9999; cfg_steps = 12'd1; cfg_dwell = 16'd1; cfg_mode = 2'b00;
    tick();
    check("reset_mid", pack(32'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    reset = 1'b0; cfg_valid = 1'b0;
    tick();
    check("reset_no_accept", pack(32'h0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    // Randomized configurations against the reference model
    for (int r = 0; r < 30; r++) begin
      logic [31:0] st;
      logic [31:0] sp;
      int          n;
      int          d;
      logic [1:0]  m;
      st = $urandom;
      sp = $urandom;
      n  = $urandom_range(0, 5);
      d  = $urandom_range(0, 4);
      m  = 2'($urandom_range(0, 3));
      go_idle();
      apply_cfg(st, sp, n, d, m);
      for (int t = 0; t < 40; t++) begin
        check($sformatf("rand%0d_m%0d_n%0d_d%0d_t%0d", r, m, n, d, t), model(st, sp, n, d, m, t));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
